// File: rtl/regwrite_sequencer_pkg.sv
// Shared definitions for the writeback sequencer: RegData mux codes, FSM state
// encoding and the request-source routing rule.
package regwrite_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT_MEM,
    ST_WAIT_MD,
    ST_WAIT_SHIFT,
    ST_WRITE,
    ST_ERR
  } state_t;

  localparam logic [3:0] SEL_227   = 4'd0;
  localparam logic [3:0] SEL_MEM   = 4'd1;
  localparam logic [3:0] SEL_ALU   = 4'd2;
  localparam logic [3:0] SEL_HI    = 4'd3;
  localparam logic [3:0] SEL_LO    = 4'd4;
  localparam logic [3:0] SEL_SHIFT = 4'd5;
  localparam logic [3:0] SEL_HALF  = 4'd6;
  localparam logic [3:0] SEL_BYTE  = 4'd7;
  localparam logic [3:0] SEL_IMM   = 4'd8;

  localparam int CNT_W = 8;

  // Code 0 belongs to the INIT write only, so a request carrying it is an error.
  function automatic state_t route_src(input logic [3:0] src);
    case (src)
      SEL_ALU, SEL_IMM:            route_src = ST_WRITE;
      SEL_MEM, SEL_HALF, SEL_BYTE: route_src = ST_WAIT_MEM;
      SEL_HI, SEL_LO:              route_src = ST_WAIT_MD;
      SEL_SHIFT:                   route_src = ST_WAIT_SHIFT;
      default:                     route_src = ST_ERR;
    endcase
  endfunction

endpackage

// File: rtl/regwrite_sequencer_wb_wait_counter.sv
// Loadable down-counter with zero flag; serves as the memory-latency count
// and as the watchdog for the HI/LO and shifter waits.
module regwrite_sequencer_wb_wait_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/regwrite_sequencer.sv
// Register-file writeback sequencer: accepts one request at a time, waits for
// its source to become valid, then issues a single-cycle write (or an error).
module regwrite_sequencer
  import regwrite_sequencer_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int TIMEOUT = 64,
  parameter int SP_REG  = 29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_src,
  input  logic [4:0] req_rd,
  input  logic       md_busy,
  input  logic       shift_done,
  output logic [3:0] regdata_sel,
  output logic [4:0] write_reg,
  output logic       reg_write,
  output logic       wb_done,
  output logic       wb_err
);

  localparam logic [CNT_W-1:0] MEM_LOAD  = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] WDOG_LOAD = CNT_W'(TIMEOUT - 1);
  localparam logic [4:0]       SP_ADDR   = 5'(SP_REG);

  state_t           state_reg, state_next;
  logic [4:0]       rd_reg, rd_next;
  logic             req_ready_reg, req_ready_next;
  logic             reg_write_reg, reg_write_next;
  logic             wb_done_reg, wb_done_next;
  logic             wb_err_reg, wb_err_next;
  logic [3:0]       regdata_sel_reg, regdata_sel_next;
  logic [4:0]       write_reg_reg, write_reg_next;
  logic             transfer;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_value;

  // req_ready is registered and only ever set on entry to IDLE.
  assign transfer = req_valid & req_ready_reg;
  assign rd_next  = transfer ? req_rd : rd_reg;

  regwrite_sequencer_wb_wait_counter #(
    .WIDTH(CNT_W)
  ) u_wait_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (cnt_load),
    .dec       (cnt_dec),
    .load_value(cnt_value),
    .zero      (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_INIT;
      rd_reg          <= '0;
      req_ready_reg   <= 1'b0;
      reg_write_reg   <= 1'b0;
      wb_done_reg     <= 1'b0;
      wb_err_reg      <= 1'b0;
      regdata_sel_reg <= '0;
      write_reg_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      rd_reg          <= rd_next;
      req_ready_reg   <= req_ready_next;
      reg_write_reg   <= reg_write_next;
      wb_done_reg     <= wb_done_next;
      wb_err_reg      <= wb_err_next;
      regdata_sel_reg <= regdata_sel_next;
      write_reg_reg   <= write_reg_next;
    end
  end

  // Watchdog waits: the awaited condition is tested before the expiry, so it wins a tie.
  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_value  = '0;
    case (state_reg)
      ST_INIT: state_next = ST_IDLE;
      ST_IDLE: begin
        if (transfer) begin
          state_next = route_src(req_src);
          cnt_load   = 1'b1;
          cnt_value  = (state_next == ST_WAIT_MEM) ? MEM_LOAD : WDOG_LOAD;
        end
      end
      ST_WAIT_MEM: begin
        if (cnt_zero) state_next = ST_WRITE;
        else          cnt_dec    = 1'b1;
      end
      ST_WAIT_MD: begin
        if (!md_busy)      state_next = ST_WRITE;
        else if (cnt_zero) state_next = ST_ERR;
        else               cnt_dec    = 1'b1;
      end
      ST_WAIT_SHIFT: begin
        if (shift_done)    state_next = ST_WRITE;
        else if (cnt_zero) state_next = ST_ERR;
        else               cnt_dec    = 1'b1;
      end
      ST_WRITE: state_next = ST_IDLE;
      ST_ERR:   state_next = ST_IDLE;
      default:  state_next = ST_INIT;
    endcase
  end

  // Output registers are loaded with the values belonging to the state being entered.
  always_comb begin
    req_ready_next   = 1'b0;
    reg_write_next   = 1'b0;
    wb_done_next     = 1'b0;
    wb_err_next      = 1'b0;
    regdata_sel_next = regdata_sel_reg;
    write_reg_next   = write_reg_reg;
    if (state_reg == ST_INIT) begin
      reg_write_next   = 1'b1;
      regdata_sel_next = SEL_227;
      write_reg_next   = SP_ADDR;
    end else begin
      if (transfer) regdata_sel_next = req_src;
      case (state_next)
        ST_IDLE: req_ready_next = 1'b1;
        ST_WRITE: begin
          reg_write_next = (rd_next != 5'd0);
          wb_done_next   = 1'b1;
          write_reg_next = rd_next;
        end
        ST_ERR:  wb_err_next = 1'b1;
        default: ;
      endcase
    end
  end

  assign req_ready   = req_ready_reg;
  assign reg_write   = reg_write_reg;
  assign wb_done     = wb_done_reg;
  assign wb_err      = wb_err_reg;
  assign regdata_sel = regdata_sel_reg;
  assign write_reg   = write_reg_reg;

endmodule

// File: tb/tb_regwrite_sequencer.sv
// Scoreboard bench for regwrite_sequencer: directed corner cases followed by
// randomized requests, checked against a cycle-level reference model.
module tb_regwrite_sequencer;

  localparam int MEM_LAT = 2;
  localparam int TIMEOUT = 64;
  localparam int SP_REG  = 29;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_src = '0;
  logic [4:0] req_rd = '0;
  logic       md_busy = 1'b0;
  logic       shift_done = 1'b0;
  logic       req_ready, reg_write, wb_done, wb_err;
  logic [3:0] regdata_sel;
  logic [4:0] write_reg;

  regwrite_sequencer #(
    .MEM_LAT(MEM_LAT),
    .TIMEOUT(TIMEOUT),
    .SP_REG (SP_REG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_rd     (req_rd),
    .md_busy    (md_busy),
    .shift_done (shift_done),
    .regdata_sel(regdata_sel),
    .write_reg  (write_reg),
    .reg_write  (reg_write),
    .wb_done    (wb_done),
    .wb_err     (wb_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         rw;
    bit         done;
    bit         err;
    bit         chk_wr;
    logic [3:0] sel;
    logic [4:0] wr;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  sel_val = 0, prev_sel = 0, sel_from = 0;
  bit  sel_known = 0;
  int  ready_exp = 0;
  bit  md_active = 0, sh_active = 0;
  int  busy_end = 0, shift_at = 0;

  function automatic void check(string name, bit ok, longint act, longint req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
  endfunction

  // Reference model: when and how a request completes, from the stated timing rules.
  function automatic ev_t model(input int src, input int rd, input int b, input int s, input int n);
    ev_t e;
    e.rw = 0; e.done = 0; e.err = 0; e.chk_wr = 1;
    e.sel = 4'(src); e.wr = 5'(rd); e.cyc = n + 1;
    case (src)
      2, 8:    e.cyc = n + 1;
      1, 6, 7: e.cyc = n + MEM_LAT + 1;
      3, 4:    e.cyc = (b < TIMEOUT) ? n + b + 2 : n + TIMEOUT + 1;
      5:       e.cyc = (s < TIMEOUT) ? n + s + 2 : n + TIMEOUT + 1;
      default: e.cyc = n + 1;
    endcase
    if ((src >= 1 && src <= 8) && !((src == 3 || src == 4) && b >= TIMEOUT)
        && !(src == 5 && s >= TIMEOUT)) begin
      e.done = 1;
      e.rw   = (rd != 0);
    end else begin
      e.err    = 1;
      e.chk_wr = 0;
    end
    return e;
  endfunction

  // Monitor: mux select every cycle, and every write/done/err event against the scoreboard.
  always @(negedge clk) begin
    int          es;
    ev_t         e;
    logic [12:0] act_sig, exp_sig;
    if (sel_known) begin
      es = (cyc >= sel_from) ? sel_val : prev_sel;
      check("regdata_sel", regdata_sel == 4'(es), regdata_sel, es);
    end
    if (reg_write === 1'b1 || wb_done === 1'b1 || wb_err === 1'b1) begin
      check("unexpected_event", exp_q.size() != 0, {reg_write, wb_done, wb_err}, 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("event_cycle", cyc == e.cyc, cyc, e.cyc);
        act_sig = {reg_write, wb_done, wb_err, req_ready, regdata_sel,
                   e.chk_wr ? write_reg : 5'd0};
        exp_sig = {e.rw, e.done, e.err, 1'b0, e.sel, e.chk_wr ? e.wr : 5'd0};
        check("event_fields", act_sig == exp_sig, act_sig, exp_sig);
      end
    end
  end

  // Handshake-irrelevant inputs get random noise; the active wait gets its schedule.
  initial forever begin
    @(posedge clk); #1;
    md_busy    = md_active ? (cyc <= busy_end) : 1'($urandom);
    shift_done = sh_active ? (cyc >= shift_at) : 1'($urandom);
  end

  task automatic do_reset(input int ncyc);
    ev_t e;
    reset = 1'b1;
    exp_q.delete();
    sel_known = 0;
    md_active = 0;
    sh_active = 0;
    repeat (ncyc) begin @(posedge clk); #1; end
    reset = 1'b0;
    e.cyc = cyc + 1; e.rw = 1; e.done = 0; e.err = 0; e.chk_wr = 1;
    e.sel = 4'd0; e.wr = 5'(SP_REG);
    exp_q.push_back(e);
    prev_sel  = 0;
    sel_val   = 0;
    sel_from  = cyc + 1;
    sel_known = 1;
    ready_exp = cyc + 2;
  endtask

  task automatic wait_ready();
    bit seen;
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      if (req_ready) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    check("ready_timing", seen && cyc == ready_exp, seen ? cyc : -1, ready_exp);
  endtask

  task automatic issue(input int src, input int rd, input int b, input int s, input int gap);
    ev_t e;
    int  n;
    wait_ready();
    req_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    n = cyc;
    req_valid = 1'b1;
    req_src   = 4'(src);
    req_rd    = 5'(rd);
    md_active = (src == 3 || src == 4);
    busy_end  = n + b;
    sh_active = (src == 5);
    shift_at  = n + 1 + s;
    e = model(src, rd, b, s, n);
    exp_q.push_back(e);
    $display("req src=%0d rd=%0d busy=%0d shift=%0d at cycle %0d -> %s at cycle %0d",
             src, rd, b, s, n, e.err ? "err" : "done", e.cyc);
    prev_sel  = sel_val;
    sel_val   = src;
    sel_from  = n + 1;
    ready_exp = e.cyc + 1;
    @(posedge clk); #1;
    // Garbage while not ready must be ignored.
    req_valid = 1'($urandom);
    req_src   = 4'($urandom);
    req_rd    = 5'($urandom);
  endtask

  initial begin
    int src, rd, b, s;
    do_reset(3);
    issue(2, 8, 0, 0, 0);
    issue(7, 9, 0, 0, 0);
    issue(4, 3, 10, 0, 1);
    issue(4, 4, 70, 0, 0);
    issue(3, 5, 0, 0, 0);
    issue(3, 6, TIMEOUT - 1, 0, 0);
    issue(4, 7, TIMEOUT, 0, 0);
    issue(5, 0, 0, 2, 0);
    issue(5, 10, 0, TIMEOUT - 1, 2);
    issue(5, 11, 0, TIMEOUT, 0);
    issue(12, 11, 0, 0, 0);
    issue(0, 1, 0, 0, 0);
    issue(8, 0, 0, 0, 0);
    issue(1, 3, 0, 0, 0);
    issue(6, 4, 0, 0, 1);
    issue(1, 12, 0, 0, 0);
    do_reset(2);
    for (int i = 0; i < 60; i++) begin
      src = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 8));
      rd  = $urandom_range(0, 31);
      b   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2))
                                        : int'($urandom_range(0, 12));
      s   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2))
                                        : int'($urandom_range(0, 12));
      issue(src, rd, b, s, $urandom_range(0, 2));
    end
    req_valid = 1'b0;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    check("drain", exp_q.size() == 0, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
